udp_tx_packetizer: RTL and testbench

// - Upstream feeder for the MAC TX path. Takes a ready/valid byte stream (e.g. captured video) and chops it into UDP payloads.
// - Writes each payload into the MAC TX payload buffer via ram_wr_en/ram_wr_data, then requests transmission.
// - Resolves the destination MAC via ARP before the first packet and waits for udp_tx_end between packets.

---
 rtl/udp_tx_packetizer_if.sv | 31 +++
 rtl/udp_tx_packetizer.sv | 165 ++++++++++++++++
 tb/tb_udp_tx_packetizer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_tx_packetizer_if.sv
// udp_tx_packetizer_if: groups the upstream stream, MAC TX buffer write port,
// MAC/ARP control handshakes and status of the UDP TX packetizer.
// The master modport is the packetizer side; the slave modport is the
// surrounding MAC/ARP/source environment.
interface udp_tx_packetizer_if;
  logic [7:0]  src_data;
  logic        src_valid;
  logic        src_ready;
  logic [7:0]  ram_wr_data;
  logic        ram_wr_en;
  logic        almost_full;
  logic [15:0] udp_send_data_length;
  logic        udp_tx_req;
  logic        udp_tx_end;
  logic        arp_request_req;
  logic        arp_found;
  logic        mac_not_exist;
  logic [15:0] pkt_count;

  modport master (
    input  src_data, src_valid, almost_full, udp_tx_end, arp_found, mac_not_exist,
    output src_ready, ram_wr_data, ram_wr_en, udp_send_data_length, udp_tx_req,
           arp_request_req, pkt_count
  );

  modport slave (
    output src_data, src_valid, almost_full, udp_tx_end, arp_found, mac_not_exist,
    input  src_ready, ram_wr_data, ram_wr_en, udp_send_data_length, udp_tx_req,
           arp_request_req, pkt_count
  );
endinterface

// File: rtl/udp_tx_packetizer.sv
// udp_tx_packetizer: chops a ready/valid byte stream into UDP payloads,
// writes them into the MAC TX payload buffer and requests transmission.
// The destination MAC is resolved via ARP whenever the cache reports a miss.
// Optional build macro UDP_TX_SEQ_HDR_EN: prefixes every payload with a
// 4-byte header {pkt_count[15:8], pkt_count[7:0], len[15:8], len[7:0]}.
// The two len bytes are only known once the packet closes, so two reserved
// zero filler bytes are written at the start and the real len bytes are
// written at REQ time for the MAC to drop into the reserved prefix.
module udp_tx_packetizer #(
  parameter int PKT_LEN      = 1024,
  parameter int FLUSH_CYCLES = 4096,
  parameter int ARP_TIMEOUT  = 125000000,
  parameter int IFG_CYCLES   = 16
) (
  input logic                 gmii_tx_clk,
  input logic                 rst_n,
  udp_tx_packetizer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, ARP_REQ, ARP_WAIT, FILL, REQ, WAIT_END, GAP
  } state_t;

  state_t state;
  state_t state_next;

  logic [15:0] count;
  logic [15:0] pkt_count;
  logic [31:0] idle_timer;
  logic [31:0] arp_timer;
  logic [31:0] gap_timer;
  logic        wr_pend;
  logic [7:0]  wr_byte;

  logic        ready;
  logic        accept;
  logic        drain;
  logic        hdr_busy;
  logic        req_ok;
  logic        flush_due;
  logic [15:0] frame_len;

`ifdef UDP_TX_SEQ_HDR_EN
  localparam logic [15:0] HDR_BYTES = 16'd4;
  logic [2:0] hdr_idx;
  logic       hdr_push;
  logic [7:0] hdr_byte;
`else
  localparam logic [15:0] HDR_BYTES = 16'd0;
`endif

  // Shared decode: the single-entry write slot drains whenever the buffer is
  // not near full, so a new byte can always enter in a cycle with almost_full low.
  always_comb begin
    drain = wr_pend & ~bus.almost_full;
`ifdef UDP_TX_SEQ_HDR_EN
    hdr_busy = (state == FILL) && (hdr_idx < 3'd4);
    hdr_push = ~bus.almost_full &&
               (hdr_busy || ((state == REQ) && ((hdr_idx == 3'd4) || (hdr_idx == 3'd5))));
    case (hdr_idx)
      3'd0:    hdr_byte = pkt_count[15:8];
      3'd1:    hdr_byte = pkt_count[7:0];
      3'd4:    hdr_byte = count[15:8];
      3'd5:    hdr_byte = count[7:0];
      default: hdr_byte = 8'h00;
    endcase
    req_ok = ~wr_pend && (hdr_idx == 3'd6);
`else
    hdr_busy = 1'b0;
    req_ok   = ~wr_pend;
`endif
    ready     = (state == FILL) && ~bus.almost_full && (count < 16'(PKT_LEN)) && ~hdr_busy;
    accept    = ready & bus.src_valid;
    flush_due = (count != 16'd0) && ~accept && (idle_timer == 32'(FLUSH_CYCLES - 1));
    frame_len = count + HDR_BYTES;
  end

  // State register.
  always_ff @(posedge gmii_tx_clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; arp_found / udp_tx_end take priority over timer expiry.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     state_next = bus.mac_not_exist ? ARP_REQ : FILL;
      ARP_REQ:  state_next = ARP_WAIT;
      ARP_WAIT: begin
        if (bus.arp_found || !bus.mac_not_exist)             state_next = FILL;
        else if (arp_timer == 32'(ARP_TIMEOUT - 1))          state_next = ARP_REQ;
      end
      FILL:     if ((count == 16'(PKT_LEN)) || flush_due)    state_next = REQ;
      REQ:      if (req_ok)                                  state_next = WAIT_END;
      WAIT_END: if (bus.udp_tx_end)                          state_next = GAP;
      GAP:      if (gap_timer == 32'(IFG_CYCLES - 1))        state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Datapath: write slot, byte count, timers and packet counter.
  always_ff @(posedge gmii_tx_clk) begin
    if (!rst_n) begin
      count      <= 16'd0;
      pkt_count  <= 16'd0;
      idle_timer <= 32'd0;
      arp_timer  <= 32'd0;
      gap_timer  <= 32'd0;
      wr_pend    <= 1'b0;
      wr_byte    <= 8'h00;
`ifdef UDP_TX_SEQ_HDR_EN
      hdr_idx    <= 3'd0;
`endif
    end else begin
      if (accept) begin
        wr_pend <= 1'b1;
        wr_byte <= bus.src_data;
      end
`ifdef UDP_TX_SEQ_HDR_EN
      else if (hdr_push) begin
        wr_pend <= 1'b1;
        wr_byte <= hdr_byte;
      end
`endif
      else if (drain) begin
        wr_pend <= 1'b0;
      end

      if (accept) begin
        count <= count + 16'd1;
      end else if ((state == WAIT_END) && bus.udp_tx_end) begin
        count <= 16'd0;
      end

      if ((state == WAIT_END) && bus.udp_tx_end) pkt_count <= pkt_count + 16'd1;

      if ((state == FILL) && (count != 16'd0) && !accept) idle_timer <= idle_timer + 32'd1;
      else                                               idle_timer <= 32'd0;

      if (state == ARP_WAIT) arp_timer <= arp_timer + 32'd1;
      else                   arp_timer <= 32'd0;

      if (state == GAP) gap_timer <= gap_timer + 32'd1;
      else              gap_timer <= 32'd0;

`ifdef UDP_TX_SEQ_HDR_EN
      if (hdr_push)          hdr_idx <= hdr_idx + 3'd1;
      else if (state == GAP) hdr_idx <= 3'd0;
`endif
    end
  end

  // Outputs decoded from state and the write slot.
  always_comb begin
    bus.src_ready            = ready;
    bus.ram_wr_en            = drain;
    bus.ram_wr_data          = wr_byte;
    bus.udp_tx_req           = (state == REQ) && req_ok;
    bus.arp_request_req      = (state == ARP_REQ);
    bus.udp_send_data_length = ((state == REQ) || (state == WAIT_END)) ? frame_len : 16'd0;
    bus.pkt_count            = pkt_count;
  end

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// tb_udp_tx_packetizer: directed bench for udp_tx_packetizer with
// PKT_LEN=8, FLUSH_CYCLES=32, ARP_TIMEOUT=100, IFG_CYCLES=16.
module tb_udp_tx_packetizer;
  localparam int PKT_LEN      = 8;
  localparam int FLUSH_CYCLES = 32;
  localparam int ARP_TIMEOUT  = 100;
  localparam int IFG_CYCLES   = 16;

  typedef struct {
    logic       af;
    logic       valid;
    logic [7:0] data;
    logic       exp_ready;
    logic       exp_wr_en;
    logic [7:0] exp_wr_data;
  } vec_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   af_viol;
  int   last_acc_cyc;
  logic [7:0] wr_q[$];
  int   wr_cyc_q[$];
  int   arp_q[$];

  udp_tx_packetizer_if bus();

  udp_tx_packetizer #(
    .PKT_LEN(PKT_LEN), .FLUSH_CYCLES(FLUSH_CYCLES),
    .ARP_TIMEOUT(ARP_TIMEOUT), .IFG_CYCLES(IFG_CYCLES)
  ) dut (
    .gmii_tx_clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // Free-running clock and posedge counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: logs writes, ARP pulses, accepts and almost_full violations.
  always @(negedge clk) begin
    if (bus.ram_wr_en) begin
      wr_q.push_back(bus.ram_wr_data);
      wr_cyc_q.push_back(cyc);
    end
    if (bus.ram_wr_en && bus.almost_full) af_viol++;
    if (bus.arp_request_req) arp_q.push_back(cyc);
    if (bus.src_valid && bus.src_ready) last_acc_cyc = cyc;
  end

  // Hard stop if something hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk); #1;
    bus.almost_full = v.af;
    bus.src_valid   = v.valid;
    bus.src_data    = v.data;
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "_src_ready"}, 32'(bus.src_ready), 0);
    checkOutput({tag, "_ram_wr_en"}, 32'(bus.ram_wr_en), 0);
    checkOutput({tag, "_ram_wr_data"}, 32'(bus.ram_wr_data), 0);
    checkOutput({tag, "_udp_tx_req"}, 32'(bus.udp_tx_req), 0);
    checkOutput({tag, "_arp_request_req"}, 32'(bus.arp_request_req), 0);
    checkOutput({tag, "_length"}, 32'(bus.udp_send_data_length), 0);
    checkOutput({tag, "_pkt_count"}, 32'(bus.pkt_count), 0);
  endtask

  // Streams nbytes consecutive values starting at first; src_valid is left high.
  task automatic streamBytes(input logic [7:0] first, input int nbytes, input bit toggle_af, output int sent);
    sent = 0;
    @(posedge clk); #1;
    bus.src_valid = 1'b1;
    bus.src_data  = first;
    for (int c = 0; c < 200 && sent < nbytes; c++) begin
      if (toggle_af) bus.almost_full = ((c / 3) % 2) == 1;
      @(negedge clk);
      if (bus.src_ready) sent++;
      @(posedge clk); #1;
      bus.src_data = first + 8'(sent);
    end
    bus.almost_full = 1'b0;
  endtask

  task automatic waitReq(input string name, input int budget, output int at_cyc, output logic [15:0] len);
    at_cyc = -1;
    len    = 16'd0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (bus.udp_tx_req) begin
        at_cyc = cyc;
        len    = bus.udp_send_data_length;
        break;
      end
    end
    checks++;
    if (at_cyc < 0) begin
      errors++;
      $display("[TB] FAIL %s: udp_tx_req not seen in %0d cycles, required one pulse", name, budget);
    end
  endtask

  task automatic pulseEnd(output int end_cyc);
    @(posedge clk); #1;
    bus.udp_tx_end = 1'b1;
    @(posedge clk); #1;
    end_cyc = cyc;
    bus.udp_tx_end = 1'b0;
  endtask

  initial begin
    vec_t        vecs[11];
    int          sent;
    int          req_at;
    int          end_at;
    logic [15:0] len;

    // FILL-state vectors starting from count=0 with an empty write slot.
    //            af    valid  data   ready wr_en wr_data
    vecs[0]  = '{1'b0, 1'b1, 8'h20, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b1, 8'h21, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 1'b1, 8'h21, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 8'h21, 1'b1, 1'b1, 8'h20};
    vecs[4]  = '{1'b0, 1'b0, 8'h22, 1'b1, 1'b1, 8'h21};
    vecs[5]  = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 8'h00};
    vecs[6]  = '{1'b1, 1'b0, 8'h23, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 1'b1, 8'h23, 1'b1, 1'b1, 8'h22};
    vecs[8]  = '{1'b0, 1'b1, 8'h24, 1'b1, 1'b1, 8'h23};
    vecs[9]  = '{1'b0, 1'b0, 8'h25, 1'b1, 1'b1, 8'h24};
    vecs[10] = '{1'b0, 1'b0, 8'h25, 1'b1, 1'b0, 8'h00};

    checks = 0; errors = 0; af_viol = 0; last_acc_cyc = 0;
    rst_n = 1'b0;
    bus.src_data = 8'h00; bus.src_valid = 1'b0; bus.almost_full = 1'b0;
    bus.udp_tx_end = 1'b0; bus.arp_found = 1'b0; bus.mac_not_exist = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkZeroOutputs("reset");

    // T1: ARP resolve after reset with cache miss
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 bus.arp_found = 1'b1;
    @(posedge clk); #1;
    bus.arp_found = 1'b0;
    bus.mac_not_exist = 1'b0;
    repeat (150) @(posedge clk);
    @(negedge clk);
    checkOutput("t1_arp_pulses", 32'(arp_q.size()), 1);
    checkOutput("t1_in_fill_ready", 32'(bus.src_ready), 1);

    // T3: two full packets from a continuous stream
    wr_q.delete(); wr_cyc_q.delete();
    streamBytes(8'h00, 8, 1'b0, sent);
    checkOutput("t3_p1_sent", 32'(sent), 8);
    waitReq("t3_p1_req", 30, req_at, len);
    checkOutput("t3_p1_len", 32'(len), 8);
    checkOutput("t3_p1_writes_before_req", 32'(wr_q.size()), 8);
    @(negedge clk);
    checkOutput("t3_req_one_cycle", 32'(bus.udp_tx_req), 0);
    pulseEnd(end_at);
    streamBytes(8'h08, 8, 1'b0, sent);
    bus.src_valid = 1'b0;
    checkOutput("t3_p2_sent", 32'(sent), 8);
    checkOutput("t3_ifg_respected", 32'((wr_cyc_q.size() > 8) && (wr_cyc_q[8] - end_at >= IFG_CYCLES)), 1);
    waitReq("t3_p2_req", 30, req_at, len);
    checkOutput("t3_p2_len", 32'(len), 8);
    pulseEnd(end_at);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("t3_pkt_count", 32'(bus.pkt_count), 2);
    checkOutput("t3_write_count", 32'(wr_q.size()), 16);
    for (int i = 0; i < 16 && i < wr_q.size(); i++)
      checkOutput($sformatf("t3_byte%0d", i), 32'(wr_q[i]), 32'(i));

    // Table vectors in FILL, leading into T5 short-packet flush
    repeat (30) @(posedge clk);
    wr_q.delete();
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_ready", i), 32'(bus.src_ready), 32'(vecs[i].exp_ready));
      checkOutput($sformatf("vec%0d_wr_en", i), 32'(bus.ram_wr_en), 32'(vecs[i].exp_wr_en));
      if (vecs[i].exp_wr_en)
        checkOutput($sformatf("vec%0d_wr_data", i), 32'(bus.ram_wr_data), 32'(vecs[i].exp_wr_data));
    end

    // T5: flush 32 cycles after the last accept with length 5
    waitReq("t5_req", 100, req_at, len);
    checkOutput("t5_len", 32'(len), 5);
    checkOutput("t5_flush_delay", 32'(req_at - (last_acc_cyc + 1)), FLUSH_CYCLES);
    checkOutput("t5_write_count", 32'(wr_q.size()), 5);
    for (int i = 0; i < 5 && i < wr_q.size(); i++)
      checkOutput($sformatf("t5_byte%0d", i), 32'(wr_q[i]), 32'h20 + 32'(i));
    pulseEnd(end_at);

    // T4: almost_full toggled every 3 cycles
    wr_q.delete();
    streamBytes(8'h30, 8, 1'b1, sent);
    bus.src_valid = 1'b0;
    checkOutput("t4_sent", 32'(sent), 8);
    waitReq("t4_req", 30, req_at, len);
    checkOutput("t4_len", 32'(len), 8);
    checkOutput("t4_write_count", 32'(wr_q.size()), 8);
    for (int i = 0; i < 8 && i < wr_q.size(); i++)
      checkOutput($sformatf("t4_byte%0d", i), 32'(wr_q[i]), 32'h30 + 32'(i));

    // T2: cache miss after the gap, no reply -> periodic retries
    bus.mac_not_exist = 1'b1;
    arp_q.delete();
    pulseEnd(end_at);
    repeat (260) @(posedge clk);
    checkOutput("t2_arp_pulse_count_ge3", 32'(arp_q.size() >= 3), 1);
    if (arp_q.size() >= 3) begin
      checkOutput("t2_first_arp_after_gap", 32'(arp_q[0] - end_at), IFG_CYCLES + 1);
      checkOutput("t2_retry_spacing0", 32'(arp_q[1] - arp_q[0]), ARP_TIMEOUT + 1);
      checkOutput("t2_retry_spacing1", 32'(arp_q[2] - arp_q[1]), ARP_TIMEOUT + 1);
    end

    // T6: reset in WAIT_END abandons the packet
    @(posedge clk); #1 bus.mac_not_exist = 1'b0;
    repeat (5) @(posedge clk);
    streamBytes(8'h40, 8, 1'b0, sent);
    bus.src_valid = 1'b0;
    waitReq("t6_req", 30, req_at, len);
    @(negedge clk);
    checkOutput("t6_len_stable", 32'(bus.udp_send_data_length), 8);
    checkOutput("t6_pkt_count_before", 32'(bus.pkt_count), 4);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkZeroOutputs("t6_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    pulseEnd(end_at);
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("t6_pkt_count_after", 32'(bus.pkt_count), 0);
    checkOutput("t6_fill_ready", 32'(bus.src_ready), 1);
    checkOutput("t6_length_after", 32'(bus.udp_send_data_length), 0);

    checkOutput("af_write_violations", 32'(af_viol), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
